// File: rtl/mdu_scheduler.sv
// rtl/mdu_scheduler.sv - E-stage multiply/divide scheduler owning HI/LO; MDU_MADD_EN enables madd/maddu
module mdu_scheduler #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        E_start,
    input  logic [3:0]  E_mdOp,
    input  logic [31:0] E_rs,
    input  logic [31:0] E_rt,
    input  logic        D_isMD,
    output logic        busy,
    output logic        stall,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state, stateNext;
    logic [3:0]  count;
    logic [63:0] result, resultNext;
    logic [31:0] hiReg, loReg;

    logic        isMult, isDiv, isLong, isMthi, isMtlo, accept;
    logic        divSigned, negQ, negR;
    logic [31:0] divA, divB, quot, rem;
    logic [63:0] sProd, uProd;

    always_comb begin
        isMult = 1'b0;
        isDiv  = 1'b0;
        isMthi = 1'b0;
        isMtlo = 1'b0;
        case (E_mdOp)
            4'd1, 4'd2: isMult = 1'b1;
            4'd3, 4'd4: isDiv  = 1'b1;
            4'd5:       isMthi = 1'b1;
            4'd6:       isMtlo = 1'b1;
`ifdef MDU_MADD_EN
            4'd7, 4'd8: isMult = 1'b1;
`endif
            default: ;
        endcase
    end

    assign isLong = isMult | isDiv;
    assign accept = E_start & (state == IDLE);

    assign sProd = $signed({{32{E_rs[31]}}, E_rs}) * $signed({{32{E_rt[31]}}, E_rt});
    assign uProd = {32'd0, E_rs} * {32'd0, E_rt};

    // Signed division runs on magnitudes so truncation and the overflow case are explicit.
    assign divSigned = (E_mdOp == 4'd3);
    assign negQ      = divSigned & (E_rs[31] ^ E_rt[31]);
    assign negR      = divSigned & E_rs[31];
    assign divA      = (divSigned && E_rs[31]) ? (~E_rs + 32'd1) : E_rs;
    assign divB      = (E_rt == 32'd0) ? 32'd1
                     : ((divSigned && E_rt[31]) ? (~E_rt + 32'd1) : E_rt);
    assign quot      = divA / divB;
    assign rem       = divA % divB;

    // A zero divisor latches the current HI/LO so completion writes them back unchanged.
    always_comb begin
        resultNext = {hiReg, loReg};
        case (E_mdOp)
            4'd1: resultNext = sProd;
            4'd2: resultNext = uProd;
            4'd3, 4'd4: begin
                if (E_rt != 32'd0) begin
                    resultNext = {(negR ? (~rem + 32'd1) : rem),
                                  (negQ ? (~quot + 32'd1) : quot)};
                end
            end
`ifdef MDU_MADD_EN
            4'd7: resultNext = {hiReg, loReg} + sProd;
            4'd8: resultNext = {hiReg, loReg} + uProd;
`endif
            default: ;
        endcase
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE: if (accept && isLong) stateNext = BUSY;
            BUSY: if (count == 4'd1) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= stateNext;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count  <= 4'd0;
            result <= 64'd0;
            hiReg  <= 32'd0;
            loReg  <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (isLong) begin
                            result <= resultNext;
                            count  <= isDiv ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
                        end else if (isMthi) begin
                            hiReg <= E_rs;
                        end else if (isMtlo) begin
                            loReg <= E_rs;
                        end
                    end
                end
                BUSY: begin
                    count <= count - 4'd1;
                    if (count == 4'd1) begin
                        hiReg <= result[63:32];
                        loReg <= result[31:0];
                    end
                end
                default: count <= 4'd0;
            endcase
        end
    end

    assign busy  = (state == BUSY);
    assign stall = ~reset & D_isMD & (busy | (E_start & isLong));
    assign HI    = hiReg;
    assign LO    = loReg;

endmodule

// File: tb/tb_mdu_scheduler.sv
// tb/tb_mdu_scheduler.sv - self-checking bench for mdu_scheduler with a behavioural HI/LO model
module tb_mdu_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        E_start;
    logic [3:0]  E_mdOp;
    logic [31:0] E_rs, E_rt;
    logic        D_isMD;
    logic        busy, stall;
    logic [31:0] HI, LO;

    int errors = 0;
    int checks = 0;
    logic [31:0] expHi = 32'd0;
    logic [31:0] expLo = 32'd0;

    mdu_scheduler #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .E_start(E_start), .E_mdOp(E_mdOp),
        .E_rs(E_rs), .E_rt(E_rt), .D_isMD(D_isMD),
        .busy(busy), .stall(stall), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int lat(input logic [3:0] op);
        case (op)
            4'd1, 4'd2: return 5;
            4'd3, 4'd4: return 10;
`ifdef MDU_MADD_EN
            4'd7, 4'd8: return 5;
`endif
            default:    return 0;
        endcase
    endfunction

    function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] rs, rt, hi, lo);
        longint sa, sb;
        int q, r;
        sa = longint'($signed(rs));
        sb = longint'($signed(rt));
        case (op)
            4'd1: return 64'(sa * sb);
            4'd2: return {32'd0, rs} * {32'd0, rt};
            4'd3: begin
                if (rt == 32'd0) return {hi, lo};
                if (rs == 32'h8000_0000 && rt == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                q = $signed(rs) / $signed(rt);
                r = $signed(rs) % $signed(rt);
                return {r, q};
            end
            4'd4: begin
                if (rt == 32'd0) return {hi, lo};
                return {rs % rt, rs / rt};
            end
            4'd5: return {rs, lo};
            4'd6: return {hi, rs};
`ifdef MDU_MADD_EN
            4'd7: return {hi, lo} + 64'(sa * sb);
            4'd8: return {hi, lo} + ({32'd0, rs} * {32'd0, rt});
`endif
            default: return {hi, lo};
        endcase
    endfunction

    task automatic run(input logic [3:0] op, input logic [31:0] rs, rt,
                       input logic dmd, input logic intrude);
        logic [63:0] exp;
        int L;
        L   = lat(op);
        exp = model(op, rs, rt, expHi, expLo);
        @(negedge clk);
        E_start = 1'b1; E_mdOp = op; E_rs = rs; E_rt = rt; D_isMD = dmd;
        #1 chk("stall_start", stall, dmd && (L > 0));
        @(negedge clk);
        E_start = 1'b0; E_mdOp = 4'd0;
        for (int i = 1; i <= L; i++) begin
            chk("busy_active", busy, 1'b1);
            chk("stall_busy", stall, dmd);
            chk("hilo_hold", {HI, LO}, {expHi, expLo});
            if (intrude && i == 2) begin
                E_start = 1'b1; E_mdOp = 4'd5; E_rs = 32'hABCD;
            end else if (intrude && i == 3) begin
                E_start = 1'b0; E_mdOp = 4'd0;
            end
            @(negedge clk);
        end
        chk("busy_done", busy, 1'b0);
        chk("stall_done", stall, 1'b0);
        chk("hilo_result", {HI, LO}, exp);
        expHi  = exp[63:32];
        expLo  = exp[31:0];
        D_isMD = 1'b0;
    endtask

    initial begin
        logic [3:0]  rop;
        logic [31:0] rrs, rrt;
        reset = 1'b1; E_start = 1'b1; E_mdOp = 4'd1; E_rs = 32'd3; E_rt = 32'd4; D_isMD = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_busy", busy, 1'b0);
        chk("reset_stall", stall, 1'b0);
        chk("reset_hilo", {HI, LO}, 64'd0);
        E_start = 1'b0; E_mdOp = 4'd0; D_isMD = 1'b0;
        reset = 1'b0;

        run(4'd1, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0);
        chk("mult_plan", {HI, LO}, {32'hFFFF_FFFF, 32'hFFFF_FFFE});
        run(4'd2, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0);
        chk("multu_plan", {HI, LO}, {32'h0000_0001, 32'hFFFF_FFFE});
        run(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        chk("div_plan", {HI, LO}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        run(4'd5, 32'h11, 32'd0, 1'b1, 1'b0);
        run(4'd6, 32'h22, 32'd0, 1'b0, 1'b0);
        run(4'd3, 32'd1234, 32'd0, 1'b0, 1'b0);
        chk("div_zero", {HI, LO}, {32'h11, 32'h22});
        run(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        chk("div_ovf", {HI, LO}, {32'h0, 32'h8000_0000});
        run(4'd1, 32'd7, 32'd9, 1'b1, 1'b0);
        run(4'd1, 32'd3, 32'd5, 1'b0, 1'b1);
        chk("mthi_ignored", HI == 32'hABCD, 1'b0);

`ifdef MDU_MADD_EN
        run(4'd5, 32'd0, 32'd0, 1'b0, 1'b0);
        run(4'd6, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0);
        run(4'd8, 32'd1, 32'd1, 1'b1, 1'b0);
        chk("maddu_plan", {HI, LO}, {32'd1, 32'd0});
`else
        run(4'd7, 32'd6, 32'd6, 1'b1, 1'b0);
        chk("madd_off", {HI, LO}, {expHi, expLo});
`endif

        for (int k = 0; k < 24; k++) begin
            rop = 4'($urandom_range(1, 8));
            rrs = $urandom;
            rrt = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            if (k % 3 == 0) rrt = rrt & 32'hFF;
            run(rop, rrs, rrt, 1'($urandom_range(0, 1)), 1'b0);
        end

        run(4'd5, 32'h5555, 32'd0, 1'b0, 1'b0);
        run(4'd6, 32'h6666, 32'd0, 1'b0, 1'b0);
        @(negedge clk);
        E_start = 1'b1; E_mdOp = 4'd3; E_rs = 32'd100; E_rt = 32'd7; D_isMD = 1'b1;
        @(negedge clk);
        E_start = 1'b0; E_mdOp = 4'd0;
        repeat (2) @(negedge clk);
        chk("busy_before_abort", busy, 1'b1);
        reset = 1'b1;
        #1;
        chk("abort_busy", busy, 1'b0);
        chk("abort_stall", stall, 1'b0);
        chk("abort_hilo", {HI, LO}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (12) @(negedge clk);
        chk("abort_no_write", {HI, LO}, 64'd0);
        chk("abort_idle", busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mdu_scheduler.md
Name: mdu_scheduler

Overview:
- Execute-stage multiply/divide scheduler for the 5-stage MIPS pipeline; sits beside the ALU in E.
- Accepts one mult/div/mthi/mtlo command per start, models the multi-cycle unit latency with a countdown, and owns the HI/LO registers.
- Drives the stall request used by hazard control when a later instruction in D needs HI/LO or the unit.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (and madd/maddu); legal range 1..15
- DIV_CYCLES, 10, busy cycles for div/divu; legal range 1..15

Ports:
- clk  input  1  pipeline clock
- reset  input  1  asynchronous, active-high reset
- E_start  input  1  E-stage command valid this cycle
- E_mdOp  input  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 madd, 8 maddu, others none
- E_rs  input  32  operand A (dividend / multiplicand / mthi-mtlo source)
- E_rt  input  32  operand B (divisor / multiplier)
- D_isMD  input  1  D-stage instruction is any mult/div/mfhi/mflo/mthi/mtlo/madd
- busy  output  1  unit executing
- stall  output  1  freeze F/D, bubble into E
- HI  output  32  HI register
- LO  output  32  LO register

Behaviour:
- Reset, asynchronous: state IDLE, counter 0, busy 0, HI 0, LO 0, latched result 0. Reset mid-operation aborts the operation with no HI/LO write.
- States: IDLE, BUSY.
- IDLE, E_start, op 1-4 (7-8 with the optional feature):
  - On the edge, latch the computed 64-bit result.
  - Load counter with MULT_CYCLES or DIV_CYCLES and go to BUSY.
- BUSY:
  - busy=1 and the counter decrements each edge.
  - On the edge where counter==1, write HI/LO from the latched result, clear counter and return to IDLE.
- Latency: start sampled at cycle N; busy is high in cycles N+1..N+L; new HI/LO are visible from cycle N+L+1.
- mthi/mtlo in IDLE: write HI or LO with E_rs at the next edge; no busy.
- Any E_start while BUSY: ignored. The pipeline stall prevents this; the bench checks that state does not change.
- Arithmetic:
  - mult: signed 32x32, {HI,LO}=product.
  - multu: unsigned 32x32, {HI,LO}=product.
  - div/divu: LO=quotient truncated toward zero, HI=remainder with the dividend's sign; signed or unsigned per op.
  - Signed 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - Divisor 0: operation still occupies DIV_CYCLES, and HI/LO remain unchanged at completion.
- stall = D_isMD & (busy | (E_start & op in {1,2,3,4,7,8})). Combinational; 0 during reset.
- HI/LO outputs are direct register outputs. Forwarding of in-flight results is not provided.

Optional Feature:
- Macro MDU_MADD_EN.
- Defined:
  - op 7 madd: {HI,LO} += signed product.
  - op 8 maddu: {HI,LO} += unsigned product.
  - Both are 64-bit wrap-around and take MULT_CYCLES.
  - The accumulate uses HI/LO values at start time.
- Undefined: ops 7/8 decode as none; no busy, no stall contribution, HI/LO untouched.

Test Plan:
- Reset release, then E_start op1 mult, E_rs=0xFFFFFFFF, E_rt=2 -> busy high for exactly 5 cycles; afterwards HI=0xFFFFFFFF, LO=0xFFFFFFFE.
- op2 multu with the same operands -> HI=0x00000001, LO=0xFFFFFFFE after 5 busy cycles. Then op3 div, E_rs=0xFFFFFFF9 (-7), E_rt=2 -> 10 busy cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- div by zero with HI=0x11, LO=0x22 preloaded via mthi/mtlo -> 10 busy cycles, then HI=0x11, LO=0x22. Then signed 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- Hazards:
  - D_isMD=1 during the start cycle and all busy cycles -> stall=1 in exactly those 6 cycles (mult), 0 after.
  - E_start op5 mthi E_rs=0xABCD while busy -> HI not 0xABCD after completion.
- Assert reset at busy cycle 3 of a div -> busy, HI, LO immediately 0; no later write.
- With MDU_MADD_EN: HI=0, LO=0xFFFFFFFF, maddu 1*1 -> HI=1, LO=0. Without the macro, op7 -> busy stays 0 and HI/LO unchanged.
